// File: rtl/vga_fb_scan.sv
// vga_fb_scan -- framebuffer scan-out for 640x480@60 VGA.
//
// A 12-bit RGB444 framebuffer (FB_W x FB_H) is written through an
// auto-incrementing port. It is scanned out with every framebuffer pixel
// replicated 2^SCALE_SHIFT times in both directions. The framebuffer read
// path is a three-stage pipeline clocked by the pixel tick:
//   S1 address/flags -> S2 RAM read -> S3 output registers.
// Syncs and colour both pass through all three stages, so they stay aligned.
//
// Optional feature macro: VGA_FB_TESTPATTERN_EN
//   defined   -> with r_enable=0, visible pixels show 8 vertical colour bars
//   undefined -> with r_enable=0, RGB is black
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   pixel_i      pixel to write {R,G,B}
//   w_enable     write strobe, one pixel per high cycle
//   r_enable     scan-out enable (0 forces black or the test pattern)
//   Hsync/Vsync  active-low syncs
//   vgaRed/vgaGreen/vgaBlue  4-bit colour outputs
//   frame_start  one-clk pulse when the scan enters h=0, v=0

module vga_fb_scan #(
  parameter int CLK_DIV     = 2,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] pixel_i,
  input  logic        w_enable,
  input  logic        r_enable,
  output logic        Hsync,
  output logic        Vsync,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue,
  output logic        frame_start
);

  localparam int FB_SIZE = FB_W * FB_H;
  localparam int AW      = (FB_SIZE > 1) ? $clog2(FB_SIZE) : 1;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(FB_SIZE - 1);

  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;

  // ---------------------------------------------------------------- memory
  logic [11:0]   mem [FB_SIZE];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] addr_s1_reg;
  logic [11:0]   rd_data_reg;
  logic          pix_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
    end else if (w_enable) begin
      wr_ptr_reg <= (wr_ptr_reg == ADDR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    end
  end

  // No reset on the array or read data so the tools map this to block RAM.
  // A read and write to the same address in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (w_enable) begin
      mem[wr_ptr_reg] <= pixel_i;
    end
    if (pix_en) begin
      rd_data_reg <= mem[addr_s1_reg];
    end
  end

  // ------------------------------------------------------------ pixel tick
  logic [DW-1:0] div_cnt_reg;

  assign pix_en = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset || pix_en) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------- counters
  logic [9:0] h_reg;
  logic [9:0] v_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (pix_en) begin
      if (h_reg == H_LAST) begin
        h_reg <= '0;
        v_reg <= (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
      end else begin
        h_reg <= h_reg + 1'b1;
      end
    end
  end

  // Constant multiply by FB_W reduces to shifts and adds; the result is only
  // meaningful inside the visible region.
  logic [AW-1:0] rd_addr_next;
  assign rd_addr_next = AW'(((32'(v_reg) >> SCALE_SHIFT) * FB_W)
                            + (32'(h_reg) >> SCALE_SHIFT));

  logic hsync_act, vsync_act, visible;
  assign hsync_act = (h_reg >= H_SYNC_S) && (h_reg <= H_SYNC_E);
  assign vsync_act = (v_reg >= V_SYNC_S) && (v_reg <= V_SYNC_E);
  assign visible   = (h_reg < H_VIS) && (v_reg < V_VIS);

`ifdef VGA_FB_TESTPATTERN_EN
  // Bar index = h / 80, built from thresholds instead of a divider.
  logic [2:0] bar_next;
  logic [2:0] bar_s1_reg;
  logic [2:0] bar_s2_reg;

  always_comb begin
    bar_next = '0;
    for (int i = 1; i < 8; i++) begin
      if (h_reg >= 10'(i * 80)) begin
        bar_next = 3'(i);
      end
    end
  end
`endif

  // -------------------------------------------------------- scan pipeline
  logic hs_s1_reg, vs_s1_reg, vis_s1_reg, ren_s1_reg;
  logic hs_s2_reg, vs_s2_reg, vis_s2_reg, ren_s2_reg;
  logic hsync_reg, vsync_reg, frame_start_reg;
  logic [11:0] rgb_reg;
  logic [11:0] rgb_next;

  always_comb begin
    rgb_next = '0;
    if (vis_s2_reg && ren_s2_reg) begin
      rgb_next = rd_data_reg;
    end
`ifdef VGA_FB_TESTPATTERN_EN
    else if (vis_s2_reg) begin
      rgb_next = {{4{bar_s2_reg[2]}}, {4{bar_s2_reg[1]}}, {4{bar_s2_reg[0]}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_s1_reg     <= '0;
      hs_s1_reg       <= 1'b0;
      vs_s1_reg       <= 1'b0;
      vis_s1_reg      <= 1'b0;
      ren_s1_reg      <= 1'b0;
      hs_s2_reg       <= 1'b0;
      vs_s2_reg       <= 1'b0;
      vis_s2_reg      <= 1'b0;
      ren_s2_reg      <= 1'b0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      rgb_reg         <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      // Registered so it is high for the clk right after h,v enter 0,0.
      frame_start_reg <= pix_en && (h_reg == H_LAST) && (v_reg == V_LAST);
      if (pix_en) begin
        addr_s1_reg <= rd_addr_next;
        hs_s1_reg   <= hsync_act;
        vs_s1_reg   <= vsync_act;
        vis_s1_reg  <= visible;
        ren_s1_reg  <= r_enable;
        hs_s2_reg   <= hs_s1_reg;
        vs_s2_reg   <= vs_s1_reg;
        vis_s2_reg  <= vis_s1_reg;
        ren_s2_reg  <= ren_s1_reg;
        hsync_reg   <= ~hs_s2_reg;
        vsync_reg   <= ~vs_s2_reg;
        rgb_reg     <= rgb_next;
      end
    end
  end

`ifdef VGA_FB_TESTPATTERN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bar_s1_reg <= '0;
      bar_s2_reg <= '0;
    end else if (pix_en) begin
      bar_s1_reg <= bar_next;
      bar_s2_reg <= bar_s1_reg;
    end
  end
`endif

  assign Hsync       = hsync_reg;
  assign Vsync       = vsync_reg;
  assign vgaRed      = rgb_reg[11:8];
  assign vgaGreen    = rgb_reg[7:4];
  assign vgaBlue     = rgb_reg[3:0];
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_fb_scan.sv
// Testbench for vga_fb_scan: a frame-level reference model predicts the pins
// from the clk count since reset and a shadow copy of the framebuffer; a
// compare process checks every cycle, and directed literal checks pin the
// model at known pixels.
module tb_vga_fb_scan;

  localparam int CLK_DIV = 2;
  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int SHIFT   = 2;
  localparam int FB_SIZE = FB_W * FB_H;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pixel_i;
  logic        w_enable;
  logic        r_enable;
  logic        Hsync, Vsync, frame_start;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;

  vga_fb_scan #(
    .CLK_DIV(CLK_DIV), .FB_W(FB_W), .FB_H(FB_H), .SCALE_SHIFT(SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .pixel_i(pixel_i), .w_enable(w_enable),
    .r_enable(r_enable), .Hsync(Hsync), .Vsync(Vsync), .vgaRed(vgaRed),
    .vgaGreen(vgaGreen), .vgaBlue(vgaBlue), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ----------------------------------------------------------- reference model
  int          n;             // clk edges since reset was released
  logic [11:0] mm [FB_SIZE];  // shadow framebuffer
  bit          mv [FB_SIZE];  // shadow word has been written
  int          wp;
  bit          ren_at  [4];   // r_enable seen at tick t (for position t-1)
  logic [11:0] dat_at  [4];   // word read at tick t (for position t-2)
  bit          datv_at [4];
  bit          exp_hs, exp_vs, exp_fs, exp_rgb_known;
  logic [11:0] exp_rgb;

  always @(posedge clk) begin
    int t, p, q, h, v, a;
    logic [2:0] b;
    if (reset) begin
      n = 0; wp = 0;
      exp_hs = 1'b1; exp_vs = 1'b1; exp_fs = 1'b0;
      exp_rgb = '0; exp_rgb_known = 1'b1;
    end else begin
      n++;
      exp_fs = 1'b0;
      if (n % CLK_DIV == 0) begin
        t = n / CLK_DIV;
        // leaving position 799,524 means the frame restarts now
        if (((t - 1) % 420000) == 419999) exp_fs = 1'b1;
        ren_at[t % 4] = r_enable;
        if (t >= 2) begin
          p = t - 2; h = p % 800; v = (p / 800) % 525;
          datv_at[t % 4] = 1'b1;
          dat_at[t % 4]  = '0;
          if (h < 640 && v < 480) begin
            a = (v >> SHIFT) * FB_W + (h >> SHIFT);
            dat_at[t % 4]  = mm[a];
            datv_at[t % 4] = mv[a];
          end
        end
        if (t >= 3) begin
          q = t - 3; h = q % 800; v = (q / 800) % 525;
          exp_hs = !(h >= 656 && h <= 751);
          exp_vs = !(v >= 490 && v <= 491);
          exp_rgb = '0; exp_rgb_known = 1'b1;
          if (h < 640 && v < 480) begin
            if (ren_at[(t - 2) % 4]) begin
              exp_rgb       = dat_at[(t - 1) % 4];
              exp_rgb_known = datv_at[(t - 1) % 4];
            end else begin
`ifdef VGA_FB_TESTPATTERN_EN
              b = 3'(h / 80);
              exp_rgb = {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
`endif
            end
          end
        end
      end
      if (w_enable) begin
        mm[wp] = pixel_i; mv[wp] = 1'b1;
        wp = (wp + 1) % FB_SIZE;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("hsync", int'(Hsync), int'(exp_hs));
      chk("vsync", int'(Vsync), int'(exp_vs));
      chk("frame_start", int'(frame_start), int'(exp_fs));
      if (exp_rgb_known) chk("rgb", int'({vgaRed, vgaGreen, vgaBlue}), int'(exp_rgb));
    end
  end

  // Hsync edge monitor for the period / width literals.
  int first_fall = -1, last_fall = -1, hs_period = -1, hs_low = -1;
  bit prev_hs = 1'b1;
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_hs && !Hsync) begin
        if (first_fall < 0) first_fall = n;
        if (last_fall >= 0 && hs_period < 0) hs_period = n - last_fall;
        last_fall = n;
      end
      if (!prev_hs && Hsync && hs_low < 0) hs_low = n - last_fall;
    end
    prev_hs = Hsync;
  end

  // ------------------------------------------------------------- helpers
  task automatic wait_n(input int target);
    int guard = 0;
    while (n != target && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (n != target) chk("wait_timeout", n, target);
  endtask

  task automatic lit_rgb(input string name, input int h, input int v, input int exp);
    wait_n(CLK_DIV * (v * 800 + h + 3));
    chk(name, int'({vgaRed, vgaGreen, vgaBlue}), exp);
  endtask

  task automatic lit_hs(input string name, input int h, input int v, input int exp);
    wait_n(CLK_DIV * (v * 800 + h + 3));
    chk(name, int'(Hsync), exp);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    reset = 1'b1; w_enable = 1'b0; r_enable = 1'b1; pixel_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hsync", int'(Hsync), 1);
    chk("reset_vsync", int'(Vsync), 1);
    chk("reset_rgb", int'({vgaRed, vgaGreen, vgaBlue}), 0);
    chk("reset_fs", int'(frame_start), 0);
    checking = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    // Phase A: fill the buffer (R,G,B first), then one extra white that wraps
    fork
      begin
        for (int k = 0; k <= FB_SIZE; k++) begin
          w_enable = 1'b1;
          if (k == 0)            pixel_i = 12'hF00;
          else if (k == 1)       pixel_i = 12'h0F0;
          else if (k == 2)       pixel_i = 12'h00F;
          else if (k == FB_SIZE) pixel_i = 12'hFFF;
          else                   pixel_i = 12'(k * 37 + 5);
          @(posedge clk); #1;
        end
        w_enable = 1'b0;
      end
      begin
        lit_rgb("l0_px0_red",   0, 0, 12'hF00);
        lit_rgb("l0_px3_red",   3, 0, 12'hF00);
        lit_rgb("l0_px4_green", 4, 0, 12'h0F0);
        lit_rgb("l0_px8_blue",  8, 0, 12'h00F);
        lit_rgb("l0_px11_blue", 11, 0, 12'h00F);
        lit_hs("hs_before_sync", 655, 0, 1);
        lit_hs("hs_sync_start",  656, 0, 0);
        lit_hs("hs_sync_end",    751, 0, 0);
        lit_hs("hs_after_sync",  752, 0, 1);
        lit_rgb("l3_px0_red",   0, 3, 12'hF00);
        lit_rgb("l3_px4_green", 4, 3, 12'h0F0);
        lit_rgb("l4_px0_row1",  0, 4, 12'h725);
      end
    join

    // Mid-frame reset with counters at h=300, v=13
    wait_n(CLK_DIV * (13 * 800 + 300));
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_hsync", int'(Hsync), 1);
    chk("rst_mid_rgb", int'({vgaRed, vgaGreen, vgaBlue}), 0);

    // Phase B: wrapped white visible; a new write lands at address 0 again
    fork
      begin
        repeat (200) @(posedge clk);
        #1 w_enable = 1'b1; pixel_i = 12'h5A5;
        @(posedge clk); #1 w_enable = 1'b0;
      end
      begin
        lit_rgb("wrap_px0_white", 0, 0, 12'hFFF);
        lit_rgb("wrap_px3_white", 3, 0, 12'hFFF);
        lit_rgb("wrap_px4_green", 4, 0, 12'h0F0);
        lit_rgb("wrap_px8_blue",  8, 0, 12'h00F);
        lit_rgb("ptr0_l1_px0",    0, 1, 12'h5A5);
        lit_rgb("ptr0_l3_px3",    3, 3, 12'h5A5);
        lit_rgb("ptr0_l3_px4",    4, 3, 12'h0F0);
      end
    join

    // r_enable drop while the counters sit at h=320, v=5
    wait_n(CLK_DIV * (5 * 800 + 320));
    r_enable = 1'b0;
    lit_rgb("ren_last_on",   319, 5, 12'h290);
`ifdef VGA_FB_TESTPATTERN_EN
    lit_rgb("ren_first_off", 320, 5, 12'hF00);
`else
    lit_rgb("ren_first_off", 320, 5, 12'h000);
`endif
    lit_hs("ren_off_hsync", 656, 5, 0);
`ifdef VGA_FB_TESTPATTERN_EN
    lit_rgb("tp_bar0",   0, 6, 12'h000);
    lit_rgb("tp_bar1",  80, 6, 12'h00F);
    lit_rgb("tp_bar7", 560, 6, 12'hFFF);
    lit_rgb("tp_bar7e", 639, 6, 12'hFFF);
`else
    lit_rgb("off_black", 560, 6, 12'h000);
`endif
    lit_rgb("blank_640", 640, 6, 12'h000);

    @(negedge clk);
    checking = 1'b0;
    chk("hs_first_fall", first_fall, (656 + 3) * CLK_DIV);
    chk("hs_period", hs_period, 800 * CLK_DIV);
    chk("hs_low", hs_low, 96 * CLK_DIV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
